pipe_stage_skid: RTL

//  Parametrised pipeline-stage register for the core pipeline: generalises the single-slot

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_sat_ctr.sv | 30 +++
 rtl/pipe_stage_skid.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for pipeline-stage registers
//
// Purpose : state encoding, default widths and small state-decode helpers
//           shared by every pipe_stage_skid instance and its helpers.
// Contents: pipe_state_e      2-bit stage occupancy state
//           PIPE_DATA_W_DEF   default payload width
//           PIPE_CNT_W_DEF    default perf-counter width
//           PIPE_BUBBLE_DEF   default bubble payload (all zeros)
//           pipe_state_valid  state holds at least one entry
//           pipe_state_room   state can take one more entry

package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W_DEF = 64;
  localparam int PIPE_CNT_W_DEF  = 32;
  localparam logic [PIPE_DATA_W_DEF-1:0] PIPE_BUBBLE_DEF = '0;

  // Main register holds a live entry whenever the stage is not empty.
  function automatic logic pipe_state_valid(input pipe_state_e s);
    return (s == PS_BUSY) || (s == PS_FULL);
  endfunction

  // Only the skid slot being occupied blocks upstream.
  function automatic logic pipe_state_room(input pipe_state_e s);
    return (s != PS_FULL);
  endfunction

endpackage

// File: rtl/pipe_sat_ctr.sv
// rtl/pipe_sat_ctr.sv - saturating event counter
//
// Purpose : counts cycles with inc_i high, sticks at all-ones, cleared only by reset.
// Ports   : clk_i  in   1      clock
//           rst_i  in   1      asynchronous active-high reset, clears the count
//           inc_i  in   1      count this cycle
//           cnt_o  out  CNT_W  current count

module pipe_sat_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline-stage register with 2-entry skid
//
// Purpose : full-throughput stage register between two pipeline stages. A main
//           register drives the output directly; a skid register catches the one
//           entry that can arrive while downstream stalls, so in_ready_o comes
//           straight from state flops with no path from out_ready_i. flush_i
//           empties the stage and loads BUBBLE_VAL in one cycle.
// Macro   : PIPE_STAGE_PERF_EN builds the stall/flush saturating counters;
//           without it both counter outputs are tied to zero.
// Ports   : clk_i        in   1       clock
//           rst_i        in   1       asynchronous active-high reset
//           flush_i      in   1       drop all held and incoming entries
//           in_valid_i   in   1       upstream entry valid
//           in_ready_o   out  1       stage can accept (registered)
//           in_data_i    in   DATA_W  upstream payload
//           out_valid_o  out  1       downstream entry valid (registered)
//           out_ready_i  in   1       downstream accepts
//           out_data_o   out  DATA_W  downstream payload (main register)
//           stall_cnt_o  out  CNT_W   cycles with out_valid_o & !out_ready_i
//           flush_cnt_o  out  CNT_W   cycles with flush_i high

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = PIPE_DATA_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = PIPE_CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // Both handshake outputs decode the state flops only.
  assign out_valid_o = pipe_state_valid(state_q);
  assign in_ready_o  = pipe_state_room(state_q);
  assign out_data_o  = main_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // A same-cycle out_fire has already been taken downstream; an in_fire is dropped.
      state_d = PS_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_BUSY;
            main_d  = in_data_i;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            // Downstream stalled while upstream still had a registered ready.
            state_d = PS_FULL;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // in_ready_o is low here, so only the drain direction can move.
          if (out_fire) begin
            state_d = PS_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PS_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;

  assign stall_inc = out_valid_o & ~out_ready_i;

  pipe_sat_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_ctr #(
    .CNT_W (CNT_W)
  ) u_flush_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
